result_writeback: RTL and testbench
===================================

# result_writeback

Receiving end of the result stream driven by the array results controller. Accepts the `BUS_WIDTH`-bit result beats, which cannot be back-pressured, and buffers them in a small FIFO. Computes the destination address of each beat in row-major matrix C (m × p, base `base_addr`). Issues memory writes over a valid/ready port and signals completion once the last beat of the whole product has been written.

## Interface
Parameters:
- `ARRAY_HEIGHT`, 4, array rows per tile (H)
- `ARRAY_WIDTH`, 32, array columns per tile (W)
- `DATA_WIDTH`, 16, bits per result element
- `BUS_WIDTH`, 256, bits per beat; `ELEMS = BUS_WIDTH/DATA_WIDTH`, `CHUNKS = W/ELEMS` (integer, ≥1)
- `FIFO_DEPTH`, 8, beat buffer depth (power of 2, ≥2)

Ports:
- `clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; latches `m`, `p`, `base_addr`
- `m` in 16: rows of C (multiple of H, nonzero)
- `p` in 16: columns of C (multiple of W, nonzero)
- `base_addr` in 32: byte address of C[0][0]
- `data_i` in BUS_WIDTH: result beat, element k in bits [(k+1)·DATA_WIDTH-1 : k·DATA_WIDTH]
- `valid_i` in 1: beat present; no ready, always consumed
- `mem_addr` out 32: byte address of `mem_wdata`
- `mem_wdata` out BUS_WIDTH: write data
- `mem_wvalid` out 1: write request
- `mem_wready` in 1: write accepted when high with `mem_wvalid`
- `busy` out 1: job active
- `done` out 1: one-cycle completion pulse
- `overflow` out 1: sticky, a beat was lost

## Operation
- FSM states:
  - IDLE: `start` latches the job, clears `overflow` and counters → RUN.
  - RUN: exit when the last beat is pushed → DRAIN.
  - DRAIN: exit when the last beat completes its memory handshake → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- Beat order within a tile is row-round-robin:
  - Beat b maps to row r = b mod H and chunk c = b div H; H·CHUNKS beats per tile.
  - Tile order: column tiles inner, row tiles outer. tr ∈ [0, m/H), tc ∈ [0, p/W).
- Address: `mem_addr = base_addr + ((tr·H + r)·p + tc·W + c·ELEMS)·(DATA_WIDTH/8)`, computed at 32 bits, wraps modulo 2^32.
- Address counters (r, c, tc, tr) advance on the memory handshake, not on the push. The address therefore always belongs to the FIFO head.
- Total beats = (m/H)·(p/W)·H·CHUNKS. The push counter and the handshake counter are separate, each 32 bits wide.
- Push:
  - `valid_i` in RUN and not full → pushed.
  - Full and a pop in the same cycle → still pushed.
  - Full with no pop → beat dropped, `overflow`=1.
- `valid_i` in IDLE, DRAIN or DONE → ignored and `overflow`=1. `overflow` is cleared only by the next `start` or by reset.
- `start` while `busy` → ignored.
- `busy` = 1 in RUN, DRAIN and DONE.
- Reset mid-job: all state is cleared immediately and the FIFO is emptied. Any write in flight is abandoned.

## Timing
- Reset values: `mem_wvalid`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `overflow`=0; FSM in IDLE.
- `start` at edge N → `busy`=1 from N+1. Beats are accepted from cycle N+1.
- A beat pushed at edge N appears with `mem_wvalid`=1 from cycle N+1 (FIFO output combinational from the head).
- With `mem_wready` held high: throughput is 1 beat/cycle and the FIFO never exceeds 1 entry.
- `mem_wvalid`, `mem_addr` and `mem_wdata` stay stable until the handshake.
- Last handshake at edge N → `done`=1 during cycle N+1, `busy`=0 at N+2.

## Structure
- Shared package `mm_pkg`: FSM state enum `wb_state_t`; the functions `elems_per_beat(BUS_WIDTH, DATA_WIDTH)` and `beats_per_tile(...)`.
- Sub-module `result_fifo`: synchronous FIFO.
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `push`, `pop`, `full`, `empty`, head data.
  - Occupancy count with wrap-around pointers; simultaneous push/pop when full or empty is legal.
- Top level: FSM, push and handshake counters, address counters.

## Test plan
All scenarios use defaults (ELEMS=16, CHUNKS=2, 8 beats/tile).
- m=4, p=32, base 0x1000, `mem_wready`=1, 8 consecutive beats → addresses 0x1000, 0x1040, 0x1080, 0x10C0, 0x1020, 0x1060, 0x10A0, 0x10E0 with data in order; `done` one cycle after the 8th handshake; `overflow`=0.
- m=8, p=64, base 0 → 32 beats; the first beat of tile (0,1) has address 0x40, of tile (1,0) 0x200; the last beat has address 0x3E0.
- `mem_wready`=0 for 20 cycles with 8 beats pushed → FIFO full, no overflow. A 9th beat → `overflow`=1, and only 8 writes occur after `mem_wready` rises.
- FIFO full, `mem_wready`=1 and `valid_i`=1 in the same cycle → push and pop both occur, no overflow, order is preserved.
- `reset_n` asserted after 3 beats → `busy`, `mem_wvalid` and `done` are 0 immediately. A new `start` runs a clean job whose first address is `base_addr`.
- `start` pulsed mid-job with a different `base_addr` → ignored; all addresses use the original base. A `valid_i` in IDLE → `overflow`=1, no write.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared definitions for the matrix-multiply result path:
//            write-back FSM state type and beat geometry helpers.
// Contents : wb_state_t      - write-back FSM states
//            elems_per_beat  - result elements carried by one bus beat
//            beats_per_tile  - beats needed to move one H x W result tile
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_t;

  function automatic int elems_per_beat(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  // A tile row of W elements is split into W/ELEMS chunks; H rows per tile.
  function automatic int beats_per_tile(input int array_height, input int array_width,
                                        input int bus_width, input int data_width);
    return array_height * (array_width / elems_per_beat(bus_width, data_width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Purpose  : Synchronous FIFO buffering result beats. Head data is presented
//            combinationally. Push while full is accepted only when a pop
//            happens in the same cycle; pop while empty is ignored.
// Ports    : clk, reset_n     - clock, async active-low reset
//            push, wdata      - write strobe and data
//            pop              - remove head entry
//            head             - data at the FIFO head
//            full, empty      - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_count = DEPTH[c_ptr_w:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_full_count);
  assign w_do_pop  = pop && !empty;
  // When full, the slot being written is the one freed by the same-cycle pop.
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : result_writeback
// Purpose  : Receives non-back-pressurable result beats, buffers them, and
//            writes each to its row-major location in matrix C over a
//            valid/ready write port. Pulses done after the final write.
// Ports    : clk, reset_n           - clock, async active-low reset
//            start, m, p, base_addr - job launch and geometry
//            data_i, valid_i        - incoming result beats
//            mem_addr, mem_wdata,
//            mem_wvalid, mem_wready - memory write port
//            busy, done, overflow   - job status
// Revision : 1.0 - initial release
// ============================================================================
module result_writeback
  import mm_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int BUS_WIDTH    = 256,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          m,
  input  logic [15:0]          p,
  input  logic [31:0]          base_addr,
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic                 valid_i,
  output logic [31:0]          mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  output logic                 mem_wvalid,
  input  logic                 mem_wready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int c_elems  = elems_per_beat(BUS_WIDTH, DATA_WIDTH);
  localparam int c_chunks = ARRAY_WIDTH / c_elems;
  localparam int c_bpt    = beats_per_tile(ARRAY_HEIGHT, ARRAY_WIDTH, BUS_WIDTH, DATA_WIDTH);
  localparam int c_bytes  = DATA_WIDTH / 8;

  wb_state_t r_state, w_next_state;

  logic [15:0] r_p;
  logic [15:0] r_ntc;        // column tiles per tile row
  logic [31:0] r_base;
  logic [31:0] r_total;
  logic [31:0] r_push_cnt;
  logic [31:0] r_hs_cnt;
  logic [15:0] r_r, r_c, r_tc, r_tr;
  logic        r_overflow;

  logic                 w_start_ok;
  logic                 w_push, w_pop, w_drop;
  logic                 w_full, w_empty;
  logic [BUS_WIDTH-1:0] w_head;
  logic [31:0]          w_total;
  logic [31:0]          w_row, w_col;

  assign w_start_ok = (r_state == WB_IDLE) && start;
  assign w_pop      = mem_wvalid && mem_wready;
  assign w_push     = valid_i && (r_state == WB_RUN) && (!w_full || w_pop);
  assign w_drop     = valid_i && !w_push;
  assign w_total    = (32'(m) / 32'(ARRAY_HEIGHT)) * (32'(p) / 32'(ARRAY_WIDTH)) * 32'(c_bpt);

  result_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (data_i),
    .pop     (w_pop),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Address is derived from the handshake-side counters, so it always
  // describes the beat currently at the FIFO head.
  assign w_row      = 32'(r_tr) * 32'(ARRAY_HEIGHT) + 32'(r_r);
  assign w_col      = 32'(r_tc) * 32'(ARRAY_WIDTH) + 32'(r_c) * 32'(c_elems);
  assign mem_addr   = r_base + (w_row * 32'(r_p) + w_col) * 32'(c_bytes);
  assign mem_wvalid = !w_empty;
  assign mem_wdata  = w_empty ? '0 : w_head;
  assign busy       = (r_state != WB_IDLE);
  assign done       = (r_state == WB_DONE);
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WB_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WB_IDLE:  if (start) w_next_state = WB_RUN;
      WB_RUN:   if (w_push && (r_push_cnt == r_total - 32'd1)) w_next_state = WB_DRAIN;
      WB_DRAIN: if (w_pop && (r_hs_cnt == r_total - 32'd1)) w_next_state = WB_DONE;
      WB_DONE:  w_next_state = WB_IDLE;
      default:  w_next_state = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p        <= '0;
      r_ntc      <= '0;
      r_base     <= '0;
      r_total    <= '0;
      r_push_cnt <= '0;
      r_hs_cnt   <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_tc       <= '0;
      r_tr       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_p        <= p;
        r_ntc      <= 16'(32'(p) / 32'(ARRAY_WIDTH));
        r_base     <= base_addr;
        r_total    <= w_total;
        r_push_cnt <= '0;
        r_hs_cnt   <= '0;
        r_r        <= '0;
        r_c        <= '0;
        r_tc       <= '0;
        r_tr       <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_push_cnt <= r_push_cnt + 32'd1;
        if (w_pop) begin
          r_hs_cnt <= r_hs_cnt + 32'd1;
          // Row-round-robin inside a tile, then chunk, then column tile, then row tile.
          if (r_r == 16'(ARRAY_HEIGHT - 1)) begin
            r_r <= '0;
            if (r_c == 16'(c_chunks - 1)) begin
              r_c <= '0;
              if (r_tc == r_ntc - 16'd1) begin
                r_tc <= '0;
                r_tr <= r_tr + 16'd1;
              end else begin
                r_tc <= r_tc + 16'd1;
              end
            end else begin
              r_c <= r_c + 16'd1;
            end
          end else begin
            r_r <= r_r + 16'd1;
          end
        end
      end
      // A lost beat in the launch cycle still counts against the new job.
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writeback
// Purpose  : Self-checking bench for result_writeback: address table,
//            randomized jobs against a geometric address model, and
//            hand-written full/overflow/reset/restart sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_writeback;

  localparam int H     = 4;
  localparam int W     = 32;
  localparam int DW    = 16;
  localparam int BW    = 256;
  localparam int ELEMS = BW / DW;
  localparam int BPT   = H * (W / ELEMS);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   m, p;
  logic [31:0]   base_addr;
  logic [BW-1:0] data_i;
  logic          valid_i;
  logic [31:0]   mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_wvalid;
  logic          mem_wready;
  logic          busy, done, overflow;

  result_writeback #(
    .ARRAY_HEIGHT (H),
    .ARRAY_WIDTH  (W),
    .DATA_WIDTH   (DW),
    .BUS_WIDTH    (BW),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .m          (m),
    .p          (p),
    .base_addr  (base_addr),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   obs_addr[$];
  logic [BW-1:0] obs_data[$];
  logic [BW-1:0] sent[$];
  int            cyc = 0, done_cnt = 0, done_at = 0, last_hs = 0;
  logic          hold_v = 1'b0;
  logic [31:0]   hold_a;
  logic [BW-1:0] hold_d;
  logic [15:0]   job_m, job_p;
  logic [31:0]   job_base;

  typedef struct {
    logic [15:0] m;
    logic [15:0] p;
    logic [31:0] base;
    int          idx;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference address: locate beat k by tile, then by row/chunk within the tile.
  function automatic logic [31:0] model_addr(input int k, input int mm, input int pp,
                                             input logic [31:0] base);
    int  tpr  = pp / W;
    int  tile = k / BPT;
    int  b    = k % BPT;
    int  tr   = tile / tpr;
    int  tc   = tile % tpr;
    int  r    = b % H;
    int  c    = b / H;
    longint off;
    off = longint'(((tr * H + r) * pp + tc * W + c * ELEMS) * (DW / 8));
    return base + off[31:0];
  endfunction

  // Observation happens mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n === 1'b1) begin
      if (hold_v && mem_wvalid) begin
        chk("stable_addr", mem_addr, hold_a);
        chkd("stable_data", mem_wdata, hold_d);
      end
      hold_v = mem_wvalid && !mem_wready;
      hold_a = mem_addr;
      hold_d = mem_wdata;
      if (mem_wvalid && mem_wready) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] d;
    for (int i = 0; i < BW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic new_job(input logic [15:0] mm, input logic [15:0] pp, input logic [31:0] base);
    obs_addr.delete();
    obs_data.delete();
    sent.delete();
    done_cnt  = 0;
    job_m     = mm;
    job_p     = pp;
    job_base  = base;
    m         = mm;
    p         = pp;
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic beat();
    logic [BW-1:0] d;
    d       = rnd_beat();
    data_i  = d;
    valid_i = 1'b1;
    sent.push_back(d);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    else chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_job(input int n, input logic exp_ovf);
    chk("n_writes", 32'(obs_addr.size()), 32'(n));
    for (int k = 0; k < obs_addr.size() && k < sent.size(); k++) begin
      chk("addr", obs_addr[k], model_addr(k, int'(job_m), int'(job_p), job_base));
      chkd("data", obs_data[k], sent[k]);
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_at), 32'(last_hs + 1));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic run_full(input logic [15:0] mm, input logic [15:0] pp, input logic [31:0] base);
    int total;
    total = (int'(mm) / H) * (int'(pp) / W) * BPT;
    mem_wready = 1'b1;
    new_job(mm, pp, base);
    for (int i = 0; i < total; i++) beat();
    wait_done(50);
    check_job(total, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    valid_i    = 1'b0;
    mem_wready = 1'b0;
    data_i     = '0;
    m          = '0;
    p          = '0;
    base_addr  = '0;

    vecs[0]  = '{16'd4, 16'd32, 32'h1000, 0, 32'h1000};
    vecs[1]  = '{16'd4, 16'd32, 32'h1000, 1, 32'h1040};
    vecs[2]  = '{16'd4, 16'd32, 32'h1000, 2, 32'h1080};
    vecs[3]  = '{16'd4, 16'd32, 32'h1000, 3, 32'h10C0};
    vecs[4]  = '{16'd4, 16'd32, 32'h1000, 4, 32'h1020};
    vecs[5]  = '{16'd4, 16'd32, 32'h1000, 5, 32'h1060};
    vecs[6]  = '{16'd4, 16'd32, 32'h1000, 6, 32'h10A0};
    vecs[7]  = '{16'd4, 16'd32, 32'h1000, 7, 32'h10E0};
    vecs[8]  = '{16'd8, 16'd64, 32'h0,    8, 32'h40};
    vecs[9]  = '{16'd8, 16'd64, 32'h0,   16, 32'h200};
    vecs[10] = '{16'd8, 16'd64, 32'h0,   31, 32'h3E0};

    // Reset state
    tick();
    tick();
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chkd("rst_wdata", mem_wdata, '0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Address table
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || vecs[i].m != vecs[i-1].m || vecs[i].p != vecs[i-1].p ||
          vecs[i].base != vecs[i-1].base)
        run_full(vecs[i].m, vecs[i].p, vecs[i].base);
      if (vecs[i].idx < obs_addr.size())
        chk($sformatf("vec%0d_addr", i), obs_addr[vecs[i].idx], vecs[i].exp_addr);
      else
        chk($sformatf("vec%0d_missing", i), 32'(obs_addr.size()), 32'(vecs[i].idx + 1));
    end

    // Randomized jobs with random back-pressure and beat gaps
    for (int it = 0; it < 6; it++) begin
      logic [15:0] rm, rp;
      logic [31:0] rb;
      int          total, guard;
      rm = 16'(4 * $urandom_range(1, 3));
      rp = 16'(32 * $urandom_range(1, 2));
      rb = $urandom;
      total = (int'(rm) / H) * (int'(rp) / W) * BPT;
      mem_wready = 1'b0;
      new_job(rm, rp, rb);
      guard = 0;
      while (sent.size() < total && guard < 2000) begin
        mem_wready = 1'($urandom % 2);
        if ((sent.size() - obs_addr.size()) < 8 && ($urandom % 4) != 0) begin
          data_i  = rnd_beat();
          valid_i = 1'b1;
          sent.push_back(data_i);
        end else begin
          valid_i = 1'b0;
        end
        tick();
        guard++;
      end
      valid_i    = 1'b0;
      mem_wready = 1'b1;
      wait_done(200);
      check_job(total, 1'b0);
    end

    // FIFO fills with no back-pressure relief, then one beat is lost
    mem_wready = 1'b0;
    new_job(16'd4, 16'd32, 32'h0);
    for (int i = 0; i < 8; i++) beat();
    repeat (12) tick();
    chk("full_no_ovf", 32'(overflow), 32'd0);
    chk("full_wvalid", 32'(mem_wvalid), 32'd1);
    chk("full_no_write", 32'(obs_addr.size()), 32'd0);
    beat();
    void'(sent.pop_back());
    chk("ninth_ovf", 32'(overflow), 32'd1);
    mem_wready = 1'b1;
    wait_done(50);
    check_job(8, 1'b1);

    // Push and pop in the same cycle while full
    mem_wready = 1'b0;
    new_job(16'd8, 16'd32, 32'h100);
    for (int i = 0; i < 8; i++) beat();
    tick();
    mem_wready = 1'b1;
    data_i     = rnd_beat();
    valid_i    = 1'b1;
    sent.push_back(data_i);
    tick();
    valid_i    = 1'b0;
    mem_wready = 1'b0;
    chk("simul_no_ovf", 32'(overflow), 32'd0);
    chk("simul_one_write", 32'(obs_addr.size()), 32'd1);
    mem_wready = 1'b1;
    for (int i = 0; i < 7; i++) beat();
    wait_done(50);
    check_job(16, 1'b0);

    // Reset in the middle of a job
    mem_wready = 1'b0;
    new_job(16'd4, 16'd32, 32'h3000);
    for (int i = 0; i < 3; i++) beat();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_full(16'd4, 16'd32, 32'h2000);
    if (obs_addr.size() > 0) chk("post_rst_first_addr", obs_addr[0], 32'h2000);

    // start during a job is ignored; then a stray beat in IDLE
    mem_wready = 1'b1;
    new_job(16'd4, 16'd32, 32'h1000);
    for (int i = 0; i < 3; i++) beat();
    start     = 1'b1;
    base_addr = 32'h5000;
    m         = 16'd8;
    tick();
    start     = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) beat();
    wait_done(50);
    check_job(8, 1'b0);
    data_i  = rnd_beat();
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    chk("idle_beat_ovf", 32'(overflow), 32'd1);
    chk("idle_beat_no_write", 32'(obs_addr.size()), 32'd8);
    chk("idle_beat_wvalid", 32'(mem_wvalid), 32'd0);
    chk("idle_beat_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
